ffsr_pulse_driver: RTL and testbench

//  Transmit side of the inc/dec pulse interface used by ffsr_pulse. Accepts a binary target count

---
 rtl/ffsr_pkg.sv | 27 ++
 rtl/therm_decode.sv | 24 ++
 rtl/ffsr_pulse_driver.sv | 98 +++++++++
 tb/tb_ffsr_pulse_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ffsr_pkg.sv
// Shared types and helpers for the ffsr pulse-interface blocks.
package ffsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ffsr_drv_state_t;

    // Widest thermometer the helpers below handle.
    localparam int unsigned MAX_W = 32;

    function automatic int unsigned therm_popcount(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [MAX_W-1:0] cnt_to_therm(input int unsigned c);
        if (c >= MAX_W) return '1;
        return (32'd1 << c) - 32'd1;
    endfunction

endpackage

// File: rtl/therm_decode.sv
// Thermometer decoder: population count plus a canonical-form check.
module therm_decode
    import ffsr_pkg::*;
#(
    parameter int unsigned INPUT_SIZE = 8,
    parameter int unsigned CNT_W      = $clog2(INPUT_SIZE + 1)
) (
    input  logic [INPUT_SIZE-1:0] therm,
    output logic [CNT_W-1:0]      cnt,
    output logic                  therm_err
);

    logic [MAX_W-1:0] wide;
    int unsigned      pop;

    // Count ones and flag any pattern that is not contiguous ones from the LSB.
    always_comb begin
        wide      = MAX_W'(therm);
        pop       = therm_popcount(wide);
        cnt       = CNT_W'(pop);
        therm_err = (wide != cnt_to_therm(pop));
    end

endmodule

// File: rtl/ffsr_pulse_driver.sv
// Drives inc/dec pulses into a downstream ffsr_pulse until a local mirror
// of its thermometer register reaches a requested count.
module ffsr_pulse_driver
    import ffsr_pkg::*;
#(
    parameter int unsigned INPUT_SIZE = 8,
    parameter int unsigned CNT_W      = $clog2(INPUT_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INPUT_SIZE-1:0] init,
    input  logic                  tgt_valid,
    input  logic [CNT_W-1:0]      tgt,
    output logic                  tgt_ready,
    output logic                  inc,
    output logic                  dec,
    output logic                  busy,
    output logic                  done,
    output logic                  clamped,
    output logic                  therm_err,
    output logic [CNT_W-1:0]      cnt,
    output logic [INPUT_SIZE-1:0] therm
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(INPUT_SIZE);

    ffsr_drv_state_t  state, state_next;
    logic [CNT_W-1:0] tgt_q;
    logic             accept;
    logic             last_step;

    therm_decode #(
        .INPUT_SIZE(INPUT_SIZE),
        .CNT_W     (CNT_W)
    ) u_decode (
        .therm    (therm),
        .cnt      (cnt),
        .therm_err(therm_err)
    );

    assign accept = tgt_valid && tgt_ready;
    assign busy   = (state == RUN) || (state == DONE);

    // Next state and pulse decode; pulses and strobes are suppressed while rst is high.
    always_comb begin
        state_next = state;
        tgt_ready  = 1'b0;
        inc        = 1'b0;
        dec        = 1'b0;
        done       = 1'b0;
        last_step  = 1'b0;
        unique case (state)
            IDLE: begin
                tgt_ready = !rst;
                if (accept) state_next = RUN;
            end
            RUN: begin
                if (therm_err || (cnt == tgt_q)) begin
                    state_next = DONE;
                end else begin
                    inc = (cnt < tgt_q) && !rst;
                    dec = (cnt > tgt_q) && !rst;
                    // Leave RUN on the final step so done follows the last pulse directly.
                    last_step = (cnt < tgt_q) ? ((tgt_q - cnt) == CNT_W'(1))
                                              : ((cnt - tgt_q) == CNT_W'(1));
                    if (last_step) state_next = DONE;
                end
            end
            DONE: begin
                done       = !rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, mirror shift register and request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            therm   <= init;
            tgt_q   <= '0;
            clamped <= 1'b0;
        end else begin
            state <= state_next;
            if (inc) begin
                therm <= {therm[INPUT_SIZE-2:0], 1'b1};
            end else if (dec) begin
                therm <= {1'b0, therm[INPUT_SIZE-1:1]};
            end
            if (accept) begin
                tgt_q   <= (tgt > MAX_CNT) ? MAX_CNT : tgt;
                clamped <= (tgt > MAX_CNT);
            end
        end
    end

endmodule

// File: tb/tb_ffsr_pulse_driver.sv
// Self-checking bench for ffsr_pulse_driver with a behavioural downstream register.
module tb_ffsr_pulse_driver;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  init;
    logic          tgt_valid;
    logic [CW-1:0] tgt;
    logic          tgt_ready, inc, dec, busy, done, clamped, therm_err;
    logic [CW-1:0] cnt;
    logic [N-1:0]  therm;

    logic [N-1:0]  ds_out;   // downstream thermometer register
    logic [N-1:0]  m_therm;  // reference mirror value
    int            vectors;
    int            miscompares;

    ffsr_pulse_driver #(
        .INPUT_SIZE(N),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .tgt_valid(tgt_valid),
        .tgt      (tgt),
        .tgt_ready(tgt_ready),
        .inc      (inc),
        .dec      (dec),
        .busy     (busy),
        .done     (done),
        .clamped  (clamped),
        .therm_err(therm_err),
        .cnt      (cnt),
        .therm    (therm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register: reloads init on rst, shifts on the pulses it receives.
    always @(posedge clk) begin
        if (rst)      ds_out <= init;
        else if (inc) ds_out <= {ds_out[N-2:0], 1'b1};
        else if (dec) ds_out <= {1'b0, ds_out[N-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mirror must track downstream every cycle and pulses must never overlap.
    always @(negedge clk) begin
        if (!rst && $time > 30) begin
            chk("mirror_vs_downstream", 32'(therm), 32'(ds_out));
            chk("inc_dec_exclusive", 32'(inc && dec), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        rst       = 1'b1;
        init      = v;
        tgt_valid = 1'b0;
        step();
        chk("rst_inc", 32'(inc), 0);
        chk("rst_dec", 32'(dec), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(tgt_ready), 0);
        chk("rst_therm", 32'(therm), 32'(v));
        rst     = 1'b0;
        m_therm = v;
        step();
        chk("ready_after_rst", 32'(tgt_ready), 1);
        chk("idle_busy", 32'(busy), 0);
    endtask

    function automatic bit is_canon(input logic [N-1:0] v);
        return int'(v) == ((1 << $countones(v)) - 1);
    endfunction

    task automatic request(input logic [CW-1:0] t, input bit poke);
        int unsigned tq, pc, n, waited;
        bit          canon, up;
        waited = 0;
        while (tgt_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk("ready_before_req", 32'(tgt_ready), 1);
        pc    = $countones(m_therm);
        canon = is_canon(m_therm);
        chk("cnt_pre", 32'(cnt), pc);
        chk("therm_err_pre", 32'(therm_err), 32'(!canon));
        tq = (t > N) ? N : t;
        up = tq > pc;
        n  = !canon ? 0 : (up ? tq - pc : pc - tq);
        tgt_valid = 1'b1;
        tgt       = t;
        step();
        tgt_valid = poke;
        tgt       = CW'($urandom_range(0, 15));
        chk("clamped", 32'(clamped), 32'(t > N));
        chk("busy_run", 32'(busy), 1);
        if (n == 0) begin
            chk("zero_inc", 32'(inc), 0);
            chk("zero_dec", 32'(dec), 0);
            chk("zero_done", 32'(done), 0);
            step();
        end else begin
            for (int unsigned i = 0; i < n; i++) begin
                chk("ready_busy", 32'(tgt_ready), 0);
                chk("pulse_inc", 32'(inc), 32'(up));
                chk("pulse_dec", 32'(dec), 32'(!up));
                chk("pulse_done", 32'(done), 0);
                m_therm = up ? {m_therm[N-2:0], 1'b1} : {1'b0, m_therm[N-1:1]};
                step();
            end
        end
        tgt_valid = 1'b0;
        chk("done_hi", 32'(done), 1);
        chk("done_inc", 32'(inc), 0);
        chk("done_dec", 32'(dec), 0);
        chk("done_therm", 32'(therm), 32'(m_therm));
        chk("done_ready", 32'(tgt_ready), 0);
        step();
        chk("done_lo", 32'(done), 0);
        chk("idle_busy_after", 32'(busy), 0);
        chk("idle_ready", 32'(tgt_ready), 1);
        chk("clamped_sticky", 32'(clamped), 32'(t > N));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        init        = 8'h07;
        tgt_valid   = 1'b0;
        tgt         = '0;
        m_therm     = '0;
        step();
        step();

        do_reset(8'h07);
        chk("reset_cnt", 32'(cnt), 3);
        chk("reset_err", 32'(therm_err), 0);

        request(4'd6, 1'b0);
        chk("therm_3f", 32'(therm), 32'h3F);
        request(4'd1, 1'b1);
        chk("therm_01", 32'(therm), 32'h01);
        chk("ds_01", 32'(ds_out), 32'h01);
        request(4'd12, 1'b0);
        chk("therm_ff", 32'(therm), 32'hFF);
        request(4'd5, 1'b0);
        request(4'd5, 1'b1);

        for (int k = 0; k < 25; k++) begin
            request(CW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a run drops the request without done.
        do_reset(8'h00);
        tgt_valid = 1'b1;
        tgt       = 4'd6;
        step();
        tgt_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("midrun_inc", 32'(inc), 1);
            m_therm = {m_therm[N-2:0], 1'b1};
            step();
        end
        chk("midrun_therm", 32'(therm), 32'h03);
        rst = 1'b1;
        #1;
        chk("rst_cycle_inc", 32'(inc), 0);
        step();
        chk("after_rst_cnt", 32'(cnt), 0);
        chk("after_rst_done", 32'(done), 0);
        chk("after_rst_inc", 32'(inc), 0);
        rst     = 1'b0;
        m_therm = 8'h00;
        step();
        chk("after_rst_done2", 32'(done), 0);
        chk("after_rst_ready", 32'(tgt_ready), 1);

        // Non-canonical mirror: zero pulses, immediate done.
        do_reset(8'h05);
        chk("noncanon_err", 32'(therm_err), 1);
        request(4'd4, 1'b0);
        chk("noncanon_therm", 32'(therm), 32'h05);

        do_reset(8'h00);
        for (int k = 0; k < 10; k++) begin
            request(CW'($urandom_range(0, 15)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
